// File: rtl/bpsk_frame_transceiver_if.sv
// Purpose : bundles the serial-line input, modulator enable and all status/sample
//           outputs of bpsk_frame_transceiver into one port.
// Latency : n/a (wiring only).
// Backpr. : n/a; mod_en is the only flow-control input (gates new modulator words).
// Ports   : master = line/controller side (drives rx_in, mod_en),
//           slave  = transceiver side (drives status pulses, rx_data, fifo_count, samples).
interface bpsk_frame_transceiver_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int SAMPLE_WIDTH = 12,
  parameter int FIFO_AW      = 2
);
  logic                           rx_in;
  logic                           mod_en;
  logic                           frame_done;
  logic                           parity_err;
  logic                           frame_err;
  logic                           overflow;
  logic [DATA_WIDTH-1:0]          rx_data;
  logic [FIFO_AW:0]               fifo_count;
  logic                           tx_busy;
  logic                           signal_valid;
  logic signed [SAMPLE_WIDTH-1:0] signal_out;

  modport master (
    output rx_in, mod_en,
    input  frame_done, parity_err, frame_err, overflow, rx_data, fifo_count,
           tx_busy, signal_valid, signal_out
  );

  modport slave (
    input  rx_in, mod_en,
    output frame_done, parity_err, frame_err, overflow, rx_data, fifo_count,
           tx_busy, signal_valid, signal_out
  );
endinterface

// File: rtl/bpsk_frame_transceiver.sv
// Purpose : oversampled serial frame receiver (optional parity, stop check) -> word FIFO
//           -> BPSK square-carrier modulator producing signed DAC samples.
// Latency : status pulses 1 cycle after the stop-bit sample; first sample 1 cycle after pop.
// Backpr. : mod_en low holds words in the FIFO; a good frame arriving while full is dropped
//           and flagged with overflow.
// Ports   : clk, arst (synchronous, active-high), bus (slave modport): rx_in, mod_en in;
//           frame_done/parity_err/frame_err/overflow pulses, rx_data, fifo_count,
//           tx_busy, signal_valid, signal_out out.
module bpsk_frame_transceiver #(
  parameter int DATA_WIDTH      = 8,
  parameter int SAMPLE_WIDTH    = 12,
  parameter int CLKS_PER_BIT    = 16,
  parameter int PARITY_MODE     = 1,
  parameter int FIFO_AW         = 2,
  parameter int SAMPLES_PER_BIT = 8,
  parameter int CARRIER_PERIOD  = 4,
  parameter int AMPLITUDE       = 2047
) (
  input logic                    clk,
  input logic                    arst,
  bpsk_frame_transceiver_if.slave bus
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int BW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int SMW   = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam int KW    = $clog2(CARRIER_PERIOD);
  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [CW-1:0]      BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]      HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]      IDX_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [SMW-1:0]     SMP_LAST  = SMW'(SAMPLES_PER_BIT - 1);
  localparam logic [KW-1:0]      CAR_LAST  = KW'(CARRIER_PERIOD - 1);
  localparam logic [KW-1:0]      CAR_HALF  = KW'(CARRIER_PERIOD / 2);
  localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic signed [SAMPLE_WIDTH-1:0] AMP_P = SAMPLE_WIDTH'(AMPLITUDE);
  localparam logic signed [SAMPLE_WIDTH-1:0] AMP_N = SAMPLE_WIDTH'(-AMPLITUDE);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } rx_state_t;

  // ---------------- receiver ----------------
  rx_state_t             rx_state;
  logic [CW-1:0]         bit_cnt;
  logic [BW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  par_bit;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  frame_done_q, parity_err_q, frame_err_q;
  logic                  bit_tick;
  logic                  par_ok;
  logic                  push;

  // After the half-bit start check the counter is zeroed, so every full-bit tick
  // lands on a bit centre.
  assign bit_tick = (bit_cnt == BIT_LAST);

  always_comb begin
    par_ok = 1'b1;
    case (PARITY_MODE)
      1:       par_ok = ~(^rx_shift ^ par_bit);
      2:       par_ok =   ^rx_shift ^ par_bit;
      default: par_ok = 1'b1;
    endcase
  end

  assign push = (rx_state == S_STOP) && bit_tick && bus.rx_in && par_ok;

  always_ff @(posedge clk) begin
    if (arst) begin
      rx_state     <= S_IDLE;
      bit_cnt      <= '0;
      bit_idx      <= '0;
      rx_shift     <= '0;
      par_bit      <= 1'b0;
      rx_data_q    <= '0;
      frame_done_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (!bus.rx_in) begin
            rx_state <= S_START;
            bit_cnt  <= '0;
          end
        end
        S_START: begin
          if (bit_cnt == HALF_LAST) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            // A start bit that is high again at its centre was a glitch.
            rx_state <= bus.rx_in ? S_IDLE : S_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            bit_cnt  <= '0;
            rx_shift <= {bus.rx_in, rx_shift[DATA_WIDTH-1:1]};
            if (bit_idx == IDX_LAST) begin
              rx_state <= (PARITY_MODE == 0) ? S_STOP : S_PARITY;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_tick) begin
            bit_cnt  <= '0;
            par_bit  <= bus.rx_in;
            rx_state <= S_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            bit_cnt <= '0;
            if (bus.rx_in) begin
              rx_data_q <= rx_shift;
              if (par_ok) frame_done_q <= 1'b1;
              else        parity_err_q <= 1'b1;
              rx_state <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              rx_state    <= S_BREAK;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          // Hold off until the line is released so a break is not read as a new start.
          if (bus.rx_in) rx_state <= S_IDLE;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- word FIFO ----------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr, rd_ptr;
  logic [FIFO_AW:0]      count;
  logic                  overflow_q;
  logic                  tx_busy_q;
  logic                  pop;
  logic                  full;
  logic                  do_push;

  assign pop     = !tx_busy_q && bus.mod_en && (count != '0);
  assign full    = (count == CNT_FULL);
  // A simultaneous pop frees a slot, so a push into a full FIFO is still accepted then.
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push && full && !pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- BPSK modulator ----------------
  logic [DATA_WIDTH-1:0] tx_word;
  logic [BW-1:0]         tx_bit;
  logic [SMW-1:0]        smp_cnt;
  logic [KW-1:0]         car_k;
  logic                  carrier_pos;

  always_ff @(posedge clk) begin
    if (arst) begin
      tx_busy_q <= 1'b0;
      tx_word   <= '0;
      tx_bit    <= '0;
      smp_cnt   <= '0;
      car_k     <= '0;
    end else if (!tx_busy_q) begin
      if (pop) begin
        tx_busy_q <= 1'b1;
        tx_word   <= mem[rd_ptr];
        tx_bit    <= '0;
        smp_cnt   <= '0;
        car_k     <= '0;
      end
    end else begin
      if (smp_cnt == SMP_LAST) begin
        // Carrier phase restarts on every bit boundary.
        smp_cnt <= '0;
        car_k   <= '0;
        tx_word <= tx_word >> 1;
        if (tx_bit == IDX_LAST) tx_busy_q <= 1'b0;
        else                    tx_bit    <= tx_bit + 1'b1;
      end else begin
        smp_cnt <= smp_cnt + 1'b1;
        car_k   <= (car_k == CAR_LAST) ? '0 : car_k + 1'b1;
      end
    end
  end

  // Sample is decoded straight from the modulator registers: positive when the current
  // bit agrees with the carrier half-cycle.
  assign carrier_pos = (car_k < CAR_HALF);

  assign bus.signal_out   = !tx_busy_q ? '0 :
                            ((tx_word[0] == carrier_pos) ? AMP_P : AMP_N);
  assign bus.signal_valid = tx_busy_q;
  assign bus.tx_busy      = tx_busy_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.parity_err   = parity_err_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.overflow     = overflow_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.fifo_count   = count;

endmodule

// File: tb/tb_bpsk_frame_transceiver.sv
// Purpose : directed, self-checking bench for bpsk_frame_transceiver with a word scoreboard.
// Latency : n/a.
// Backpr. : drives mod_en to hold and release the modulator.
module tb_bpsk_frame_transceiver;
  localparam int DW  = 8;
  localparam int SW  = 12;
  localparam int CPB = 4;
  localparam int AW  = 2;
  localparam int SPB = 4;
  localparam int CP  = 4;
  localparam int AMP = 100;
  localparam int WORD_SAMPLES = DW * SPB;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  bpsk_frame_transceiver_if #(.DATA_WIDTH(DW), .SAMPLE_WIDTH(SW), .FIFO_AW(AW)) bus ();

  bpsk_frame_transceiver #(
    .DATA_WIDTH(DW), .SAMPLE_WIDTH(SW), .CLKS_PER_BIT(CPB), .PARITY_MODE(1),
    .FIFO_AW(AW), .SAMPLES_PER_BIT(SPB), .CARRIER_PERIOD(CP), .AMPLITUDE(AMP)
  ) dut (
    .clk (clk),
    .arst(arst),
    .bus (bus)
  );

  int cmp_cnt  = 0;
  int fail_cnt = 0;
  int n_done = 0, n_perr = 0, n_ferr = 0, n_ovf = 0;
  int n_samples = 0;
  int run_len = 0;
  logic prev_valid = 1'b0;
  logic [DW-1:0] cur_word = '0;
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected sample from first principles: +AMP when bit value matches the carrier half.
  function automatic int exp_sample(input logic [DW-1:0] w, input int idx);
    int b;
    int k;
    logic pos;
    b   = idx / SPB;
    k   = (idx % SPB) % CP;
    pos = (k < CP / 2);
    return (w[b] == pos) ? AMP : -AMP;
  endfunction

  // Status pulse counters.
  initial forever begin
    @(negedge clk);
    if (bus.frame_done) n_done++;
    if (bus.parity_err) n_perr++;
    if (bus.frame_err)  n_ferr++;
    if (bus.overflow)   n_ovf++;
  end

  // Modulator monitor: pops the scoreboard at the first sample of each word.
  initial forever begin
    @(negedge clk);
    if (arst) begin
      run_len    = 0;
      prev_valid = 1'b0;
    end else begin
      if (bus.signal_valid) begin
        if (run_len == 0) begin
          chk("mod_word_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) cur_word = exp_q.pop_front();
        end
        chk("mod_sample", 32'($signed(bus.signal_out)),
            32'(exp_sample(cur_word, run_len % WORD_SAMPLES)));
        run_len++;
        n_samples++;
      end else if (prev_valid) begin
        chk("mod_word_len", 32'(run_len), 32'(WORD_SAMPLES));
        chk("mod_busy_after", 32'(bus.tx_busy), 32'd0);
        chk("mod_idle_zero", 32'($signed(bus.signal_out)), 32'd0);
        run_len = 0;
      end
      prev_valid = bus.signal_valid;
    end
  end

  task automatic line_bit(input logic b);
    bus.rx_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic stop_b);
    line_bit(1'b0);
    for (int i = 0; i < DW; i++) line_bit(d[i]);
    line_bit(p);
    line_bit(stop_b);
    if (stop_b) begin
      bus.rx_in = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  // Even parity bit; the scoreboard gets the word unless the FIFO is expected full.
  task automatic good_frame(input logic [DW-1:0] d, input bit dropped);
    if (!dropped) exp_q.push_back(d);
    send_frame(d, ^d, 1'b1);
  endtask

  task automatic wait_drained(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.fifo_count == '0 && !bus.tx_busy) break;
    end
    chk("drain_in_time", 32'(i < budget), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_busy(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.tx_busy) break;
    end
    chk("busy_in_time", 32'(i < budget), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pulses"}, 32'({bus.frame_done, bus.parity_err, bus.frame_err, bus.overflow}), 32'd0);
    chk({tag, "_rx_data"}, 32'(bus.rx_data), 32'd0);
    chk({tag, "_fifo_count"}, 32'(bus.fifo_count), 32'd0);
    chk({tag, "_tx"}, 32'({bus.tx_busy, bus.signal_valid}), 32'd0);
    chk({tag, "_signal_out"}, 32'($signed(bus.signal_out)), 32'd0);
  endtask

  initial begin
    int base;
    arst       = 1'b1;
    bus.rx_in  = 1'b1;
    bus.mod_en = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    arst = 1'b0;
    @(negedge clk);

    // Good frame 0xA5, even parity bit 0.
    good_frame(8'hA5, 1'b0);
    chk("t1_frame_done", 32'(n_done), 32'd1);
    chk("t1_rx_data", 32'(bus.rx_data), 32'hA5);
    chk("t1_fifo_count", 32'(bus.fifo_count), 32'd1);
    chk("t1_no_perr", 32'(n_perr), 32'd0);

    // Same payload with wrong parity.
    send_frame(8'hA5, 1'b1, 1'b1);
    chk("t2_parity_err", 32'(n_perr), 32'd1);
    chk("t2_no_done", 32'(n_done), 32'd1);
    chk("t2_fifo_count", 32'(bus.fifo_count), 32'd1);

    // Stop bit low, line held low as a break, then released.
    send_frame(8'h3C, 1'b0, 1'b0);
    bus.rx_in = 1'b0;
    repeat (20) @(negedge clk);
    bus.rx_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("t3_frame_err", 32'(n_ferr), 32'd1);
    chk("t3_no_perr", 32'(n_perr), 32'd1);
    chk("t3_no_done", 32'(n_done), 32'd1);
    good_frame(8'h3C, 1'b0);
    chk("t3_recover_done", 32'(n_done), 32'd2);
    chk("t3_recover_count", 32'(bus.fifo_count), 32'd2);
    chk("t3_single_ferr", 32'(n_ferr), 32'd1);

    // Fill the 4-deep FIFO, fifth good frame overflows.
    good_frame(8'h00, 1'b0);
    good_frame(8'hFF, 1'b0);
    chk("t4_count_full", 32'(bus.fifo_count), 32'd4);
    chk("t4_no_ovf_yet", 32'(n_ovf), 32'd0);
    good_frame(8'h81, 1'b1);
    chk("t4_overflow", 32'(n_ovf), 32'd1);
    chk("t4_done_5", 32'(n_done), 32'd5);
    chk("t4_count_held", 32'(bus.fifo_count), 32'd4);
    chk("t4_rx_data", 32'(bus.rx_data), 32'h81);

    // Drain the four stored words.
    bus.mod_en = 1'b1;
    wait_drained(2000);
    chk("drain_samples", 32'(n_samples), 32'(4 * WORD_SAMPLES));
    chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);

    // mod_en dropped mid-word: word 0x01 finishes, 0x02 stays queued.
    bus.mod_en = 1'b0;
    good_frame(8'h01, 1'b0);
    good_frame(8'h02, 1'b0);
    chk("t5_count_2", 32'(bus.fifo_count), 32'd2);
    base = n_samples;
    bus.mod_en = 1'b1;
    wait_busy(50);
    bus.mod_en = 1'b0;
    repeat (60) @(negedge clk);
    chk("t5_hold_count", 32'(bus.fifo_count), 32'd1);
    chk("t5_one_word", 32'(n_samples - base), 32'(WORD_SAMPLES));
    chk("t5_idle", 32'(bus.tx_busy), 32'd0);
    bus.mod_en = 1'b1;
    wait_drained(500);
    chk("t5_two_words", 32'(n_samples - base), 32'(2 * WORD_SAMPLES));

    // One-cycle glitch shorter than half a bit.
    base = n_done + n_perr + n_ferr;
    bus.rx_in = 1'b0;
    @(negedge clk);
    bus.rx_in = 1'b1;
    repeat (60) @(negedge clk);
    chk("t6_glitch_quiet", 32'(n_done + n_perr + n_ferr), 32'(base));
    chk("t6_glitch_count", 32'(bus.fifo_count), 32'd0);

    // Reset in the middle of the data bits.
    line_bit(1'b0);
    line_bit(1'b1);
    line_bit(1'b1);
    arst      = 1'b1;
    bus.rx_in = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_mid_data");
    arst = 1'b0;
    repeat (60) @(negedge clk);
    chk("rst_mid_data_quiet", 32'(n_done + n_perr + n_ferr), 32'(base));

    // Reset in the middle of a modulated word with another word queued.
    bus.mod_en = 1'b0;
    good_frame(8'h55, 1'b0);
    good_frame(8'h0F, 1'b0);
    chk("rst_mod_count_2", 32'(bus.fifo_count), 32'd2);
    bus.mod_en = 1'b1;
    wait_busy(50);
    repeat (5) @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_mid_mod");
    exp_q.delete();
    arst = 1'b0;
    base = n_samples;
    repeat (80) @(negedge clk);
    chk("rst_mod_no_samples", 32'(n_samples), 32'(base));
    chk("rst_mod_idle", 32'(bus.tx_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
